lcd_ctrl: RTL and testbench

LCD_CTRL -- requirements
Module: lcd_ctrl

---
 rtl/lcd_ctrl.sv | 171 +++++++++++++++++
 tb/tb_lcd_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// HD44780-style LCD write sequencer driven by a memory-mapped LSU word.
// Each accepted EN request produces one setup/pulse/hold strobe followed by an execution wait.
module lcd_ctrl #(
  parameter int unsigned SETUP_CYC     = 2,
  parameter int unsigned PULSE_CYC     = 12,
  parameter int unsigned HOLD_CYC      = 2,
  parameter int unsigned EXEC_CYC      = 2000,
  parameter int unsigned LONG_EXEC_CYC = 82000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_lcd_word,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_status
);

  // A programmed length of 0 is stretched to a single cycle.
  localparam int unsigned SETUP_E = (SETUP_CYC     == 0) ? 1 : SETUP_CYC;
  localparam int unsigned PULSE_E = (PULSE_CYC     == 0) ? 1 : PULSE_CYC;
  localparam int unsigned HOLD_E  = (HOLD_CYC      == 0) ? 1 : HOLD_CYC;
  localparam int unsigned EXEC_E  = (EXEC_CYC      == 0) ? 1 : EXEC_CYC;
  localparam int unsigned LONG_E  = (LONG_EXEC_CYC == 0) ? 1 : LONG_EXEC_CYC;

  localparam int unsigned MAX_AB  = (SETUP_E > PULSE_E) ? SETUP_E : PULSE_E;
  localparam int unsigned MAX_ABC = (MAX_AB > HOLD_E) ? MAX_AB : HOLD_E;
  localparam int unsigned MAX_DE  = (EXEC_E > LONG_E) ? EXEC_E : LONG_E;
  localparam int unsigned MAXC    = (MAX_ABC > MAX_DE) ? MAX_ABC : MAX_DE;
  localparam int unsigned CW      = ($clog2(MAXC + 1) > 17) ? $clog2(MAXC + 1) : 17;

  localparam logic [CW-1:0] SETUP_L = CW'(SETUP_E);
  localparam logic [CW-1:0] PULSE_L = CW'(PULSE_E);
  localparam logic [CW-1:0] HOLD_L  = CW'(HOLD_E);
  localparam logic [CW-1:0] EXEC_L  = CW'(EXEC_E);
  localparam logic [CW-1:0] LONG_L  = CW'(LONG_E);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    EXEC  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            en_q;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;
  logic            on_q;
  logic            done_q, done_d;
  logic            ovr_q, ovr_d;
  logic            rwe_q, rwe_d;

  logic            req;
  logic            req_rw;
  logic            cnt_last;
  logic            long_cmd;

  assign req      = i_lcd_word[10] & ~en_q;
  assign req_rw   = i_lcd_word[8];
  assign cnt_last = (cnt_q <= CW'(1));
  // Clear display (0x01) and return home (0x02) need the long execution wait.
  assign long_cmd = ~rs_q & ((data_q == 8'h01) || (data_q == 8'h02));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    rwe_d   = rwe_q;

    if (req) begin
      if (state_q != IDLE) begin
        ovr_d = 1'b1;
      end else if (req_rw) begin
        rwe_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (req && !req_rw) begin
          rs_d    = i_lcd_word[9];
          data_d  = i_lcd_word[7:0];
          cnt_d   = SETUP_L;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_last) begin
          cnt_d   = PULSE_L;
          state_d = PULSE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PULSE: begin
        if (cnt_last) begin
          cnt_d   = HOLD_L;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        if (cnt_last) begin
          cnt_d   = long_cmd ? LONG_L : EXEC_L;
          state_d = EXEC;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      EXEC: begin
        if (cnt_last) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // en_q resets high so an EN bit already set at reset release is not a new request.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b1;
      rs_q    <= 1'b0;
      data_q  <= '0;
      on_q    <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      rwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= i_lcd_word[10];
      rs_q    <= rs_d;
      data_q  <= data_d;
      on_q    <= i_lcd_word[31];
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      rwe_q   <= rwe_d;
    end
  end

  assign o_lcd_on   = on_q;
  assign o_lcd_en   = (state_q == PULSE);
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_data = data_q;
  assign o_busy     = (state_q != IDLE);
  assign o_done     = done_q;
  assign o_status   = {29'd0, rwe_q, ovr_q, (state_q != IDLE)};

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened execution waits; strobe timing uses the defaults.
module tb_lcd_ctrl;

  localparam int unsigned SETUP = 2;
  localparam int unsigned PULSE = 12;
  localparam int unsigned HOLD  = 2;
  localparam int unsigned EXEC  = 40;
  localparam int unsigned LONG  = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] word = '0;
  logic        lcd_on, lcd_en, lcd_rs, lcd_rw, busy, done;
  logic [7:0]  lcd_data;
  logic [31:0] status;

  int pass_cnt = 0;
  int total    = 0;
  int en_rises = 0;
  int done_cnt = 0;
  logic en_prev = 1'b0;

  lcd_ctrl #(
    .SETUP_CYC    (SETUP),
    .PULSE_CYC    (PULSE),
    .HOLD_CYC     (HOLD),
    .EXEC_CYC     (EXEC),
    .LONG_EXEC_CYC(LONG)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_lcd_word(word),
    .o_lcd_on  (lcd_on),
    .o_lcd_en  (lcd_en),
    .o_lcd_rs  (lcd_rs),
    .o_lcd_rw  (lcd_rw),
    .o_lcd_data(lcd_data),
    .o_busy    (busy),
    .o_done    (done),
    .o_status  (status)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (lcd_en && !en_prev) en_rises++;
    en_prev = lcd_en;
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drops EN for a cycle, then presents a fresh request (accepted on the next edge).
  task automatic issue(input logic rs, input logic rw, input logic [7:0] data);
    word[10] = 1'b0;
    tick();
    word = '0;
    word[10] = 1'b1;
    word[9] = rs;
    word[8] = rw;
    word[7:0] = data;
  endtask

  task automatic measure(input logic rs, input logic [7:0] data,
                         output int s, output int p, output int t, output logic stable);
    stable = 1'b1;
    s = 0;
    while (!lcd_en && s < 100) begin
      tick(); s++;
      if (lcd_data !== data || lcd_rs !== rs) stable = 1'b0;
    end
    p = 0;
    while (lcd_en && p < 100) begin
      tick(); p++;
      if (lcd_data !== data || lcd_rs !== rs) stable = 1'b0;
    end
    t = 0;
    while (!done && t < 1000) begin
      tick(); t++;
      if (lcd_data !== data || lcd_rs !== rs) stable = 1'b0;
    end
  endtask

  task automatic run_cmd(input string tag, input logic rs, input logic [7:0] data, input int exec_exp);
    int s, p, t;
    logic st;
    issue(rs, 1'b0, data);
    tick();
    check({tag, "_busy_next"}, 32'(busy), 32'd1);
    check({tag, "_en_low_setup"}, 32'(lcd_en), 32'd0);
    measure(rs, data, s, p, t, st);
    check({tag, "_setup_cyc"}, 32'(s), 32'(SETUP));
    check({tag, "_pulse_cyc"}, 32'(p), 32'(PULSE));
    check({tag, "_hold_exec_cyc"}, 32'(t), 32'(HOLD + exec_exp));
    check({tag, "_rs_data_stable"}, 32'(st), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    tick();
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int r0, d0, k;

    // Reset state
    tick(); tick();
    check("rst_status", status, 32'h0);
    check("rst_en", 32'(lcd_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(lcd_data), 32'h0);
    check("rst_rw", 32'(lcd_rw), 32'd0);
    rst = 1'b0;
    tick();

    word[31] = 1'b1;
    tick();
    check("on_copy", 32'(lcd_on), 32'd1);
    word[31] = 1'b0;
    tick();
    check("on_clear", 32'(lcd_on), 32'd0);

    // Normal write, long clear, normal function-set, RS=1 with 0x02 stays short
    run_cmd("wr41", 1'b1, 8'h41, EXEC);
    run_cmd("clr01", 1'b0, 8'h01, LONG);
    run_cmd("fs38", 1'b0, 8'h38, EXEC);
    run_cmd("home02", 1'b0, 8'h02, LONG);
    run_cmd("rs1_02", 1'b1, 8'h02, EXEC);
    check("status_clean", status, 32'h0);

    // Second request during PULSE
    r0 = en_rises; d0 = done_cnt;
    issue(1'b1, 1'b0, 8'h41);
    tick();
    for (int i = 0; i < 5; i++) tick();
    check("ovr_in_pulse", 32'(lcd_en), 32'd1);
    word[10] = 1'b0;
    tick();
    word[10] = 1'b1;
    tick();
    check("ovr_status_busy", status, 32'h3);
    k = 0;
    while (!done && k < 500) begin tick(); k++; end
    check("ovr_done_seen", 32'(done), 32'd1);
    check("ovr_status_done", status, 32'h2);
    tick();
    check("ovr_single_strobe", 32'(en_rises - r0), 32'd1);
    check("ovr_single_done", 32'(done_cnt - d0), 32'd1);

    // RW=1 request is rejected
    rst = 1'b1; tick(); rst = 1'b0;
    word = '0; tick(); tick();
    r0 = en_rises;
    issue(1'b0, 1'b1, 8'h41);
    tick();
    check("rw_busy", 32'(busy), 32'd0);
    check("rw_status", status, 32'h4);
    for (int i = 0; i < 50; i++) tick();
    check("rw_no_strobe", 32'(en_rises - r0), 32'd0);

    // Reset during PULSE aborts; EN held across release
    rst = 1'b1; tick(); rst = 1'b0;
    word = '0; tick(); tick();
    issue(1'b1, 1'b0, 8'h55);
    tick();
    for (int i = 0; i < 4; i++) tick();
    check("abort_in_pulse", 32'(lcd_en), 32'd1);
    r0 = en_rises; d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("abort_en_low", 32'(lcd_en), 32'd0);
    check("abort_status", status, 32'h0);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    check("abort_no_restart", 32'(en_rises - r0), 32'd0);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);

    // EN held high for a long time yields one command
    d0 = done_cnt;
    issue(1'b1, 1'b0, 8'h42);
    for (int i = 0; i < 5000; i++) tick();
    check("hold_en_one_done", 32'(done_cnt - d0), 32'd1);
    check("hold_en_status", status, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
